// File: rtl/mc_pkg.sv
// Shared types and codes for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  localparam logic [4:0] ALU_NOP = 5'b11111;

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic regwrite;
  } ctrl_t;

  // No ALU work, no control transfer and no store: nothing the datapath can do.
  function automatic logic is_illegal(input logic [4:0] alu, input logic [1:0] br,
                                      input logic memwrite);
    return (alu == ALU_NOP) && (br == SEL_SEQ) && !memwrite;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter; expired flags the last wait cycle allowed before a timeout.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: turns the decoder control word into timed datapath
// enables, handshakes with instruction/data memory and counts retired instructions.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic             cu_memtoreg,
  input  logic             cu_memwrite,
  input  logic             cu_regwrite,
  input  logic [4:0]       cu_alucontrol,
  input  logic [1:0]       cu_branch,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  state_t state;
  state_t fetch_next;
  ctrl_t  ctrl;
  logic   waiting;
  logic   ready;
  logic   expired;
  logic   retire;

  assign waiting = (state == FETCH) || (state == MEM);
  assign ready   = (state == FETCH) ? imem_ready : dmem_ready;

  // Clearing whenever not waiting (or on completion) is the same as clearing on entry.
  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .clr     (rst || !waiting || ready),
    .en      (waiting && !ready),
    .expired (expired)
  );

  assign fetch_next = halt ? HALT : FETCH;

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = SEL_SEQ;
    reg_we   = 1'b0;
    retire   = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      EXEC: begin
        if (cu_branch != SEL_SEQ) begin
          pc_we  = 1'b1;
          pc_sel = cu_branch;
          retire = 1'b1;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl.memwrite;
        if (dmem_ready && ctrl.memwrite) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      WB: begin
        reg_we = ctrl.regwrite;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      ctrl    <= '0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      unique case (state)
        FETCH: begin
          if (imem_ready)   state <= DECODE;
          else if (expired) state <= ERR;
        end
        DECODE: begin
          ctrl  <= '{memtoreg: cu_memtoreg, memwrite: cu_memwrite, regwrite: cu_regwrite};
          state <= is_illegal(cu_alucontrol, cu_branch, cu_memwrite) ? ERR : EXEC;
        end
        EXEC: begin
          if (cu_branch != SEL_SEQ)              state <= fetch_next;
          else if (ctrl.memtoreg || ctrl.memwrite) state <= MEM;
          else                                   state <= WB;
        end
        MEM: begin
          if (dmem_ready)   state <= ctrl.memwrite ? fetch_next : WB;
          else if (expired) state <= ERR;
        end
        WB:   state <= fetch_next;
        HALT: if (!halt) state <= FETCH;
        ERR:  state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

  assign busy    = (state != HALT) && (state != ERR);
  assign err     = (state == ERR);
  assign state_o = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed scoreboard bench for mc_sequencer (TIMEOUT=4, CNT_W=4).
module tb_mc_sequencer;
  import mc_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          halt = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          cu_memtoreg = 1'b0;
  logic          cu_memwrite = 1'b0;
  logic          cu_regwrite = 1'b0;
  logic [4:0]    cu_alucontrol = 5'd0;
  logic [1:0]    cu_branch = 2'd0;
  logic          imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, busy, err;
  logic [1:0]    pc_sel;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  mc_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .ir_we         (ir_we),
    .cu_memtoreg   (cu_memtoreg),
    .cu_memwrite   (cu_memwrite),
    .cu_regwrite   (cu_regwrite),
    .cu_alucontrol (cu_alucontrol),
    .cu_branch     (cu_branch),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ready    (dmem_ready),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .reg_we        (reg_we),
    .busy          (busy),
    .err           (err),
    .instret       (instret),
    .state_o       (state_o)
  );

  typedef struct packed {
    int         lat;
    logic [1:0] sel;
    logic       regwe;
    int         dreqs;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            failures = 0;
  int unsigned   iw_cfg = 0, dw_cfg = 0, icnt = 0, dcnt = 0;
  logic [CW-1:0] exp_instret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: memories answer after their configured number of wait cycles.
  task automatic step();
    @(negedge clk);
    #1;
    imem_ready = imem_req && (icnt >= iw_cfg);
    dmem_ready = dmem_req && (dcnt >= dw_cfg);
    #1;
    if (imem_req && !imem_ready) icnt++; else icnt = 0;
    if (dmem_req && !dmem_ready) dcnt++; else dcnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("reset_strobes", {pc_we, reg_we, ir_we, dmem_req}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = '0;
    icnt = 0;
    dcnt = 0;
  endtask

  task automatic run_instr(input logic mr, input logic mw, input logic rw,
                           input logic [4:0] alu, input logic [1:0] br,
                           input int unsigned iw, input int unsigned dw, input logic hlt);
    exp_t e;
    exp_t got;
    int   cyc = 0;
    int   dreq = 0;
    logic done = 1'b0;
    e.lat   = (br != 2'b00) ? 3 + int'(iw) :
              mw ? 4 + int'(iw + dw) :
              mr ? 5 + int'(iw + dw) : 4 + int'(iw);
    e.sel   = br;
    e.regwe = (br == 2'b00 && !mw) ? rw : 1'b0;
    e.dreqs = (br == 2'b00 && (mr || mw)) ? int'(dw) + 1 : 0;
    sbq.push_back(e);
    iw_cfg = iw;
    dw_cfg = dw;
    icnt = 0;
    dcnt = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      step();
      cyc++;
      if (cyc == 1) begin
        cu_memtoreg = mr; cu_memwrite = mw; cu_regwrite = rw;
        cu_alucontrol = alu; cu_branch = br; halt = hlt;
        chk("first_cycle", {busy, imem_req, state_o}, {2'b11, 3'd0});
        chk("instret", instret, exp_instret);
      end
      if (ir_we) chk("ir_we_cycle", cyc, iw + 1);
      if (dmem_req) begin
        dreq++;
        chk("dmem_we", dmem_we, mw);
      end
      if (pc_we) begin
        got = sbq.pop_front();
        chk("latency", cyc, got.lat);
        chk("pc_sel", pc_sel, got.sel);
        chk("reg_we", reg_we, got.regwe);
        chk("dmem_cycles", dreq, got.dreqs);
        exp_instret++;
        done = 1'b1;
      end
    end
    chk("retire_seen", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    //        mr    mw    rw    alu       br     iw dw hlt
    run_instr(1'b0, 1'b0, 1'b1, 5'b00000, 2'b00, 0, 0, 1'b0); // add
    run_instr(1'b1, 1'b0, 1'b1, 5'b00000, 2'b00, 0, 3, 1'b0); // lw, 3 waits
    run_instr(1'b0, 1'b1, 1'b0, 5'b00000, 2'b00, 0, 0, 1'b0); // sw
    run_instr(1'b0, 1'b1, 1'b0, 5'b00000, 2'b00, 0, 3, 1'b0); // sw, ready on last allowed cycle
    run_instr(1'b0, 1'b0, 1'b0, 5'b01101, 2'b01, 0, 0, 1'b0); // beq taken
    run_instr(1'b0, 1'b0, 1'b0, ALU_NOP,  2'b11, 0, 0, 1'b0); // jr
    run_instr(1'b0, 1'b0, 1'b1, ALU_NOP,  2'b10, 0, 0, 1'b0); // jal: no reg_we from sequencer
    run_instr(1'b0, 1'b0, 1'b0, 5'b01101, 2'b00, 0, 0, 1'b0); // beq not taken
    run_instr(1'b0, 1'b0, 1'b1, 5'b00000, 2'b00, 3, 0, 1'b0); // add, imem ready on 4th wait
    run_instr(1'b1, 1'b0, 1'b1, 5'b00000, 2'b00, 0, 0, 1'b0); // lw zero-wait
    run_instr(1'b0, 1'b0, 1'b1, 5'b00000, 2'b00, 0, 0, 1'b1); // add with halt held

    step();
    chk("halt_enter", {busy, imem_req, state_o}, {2'b00, 3'd5});
    chk("halt_instret", instret, exp_instret);
    step();
    chk("halt_hold", state_o, 3'd5);
    halt = 1'b0;
    step();
    chk("halt_exit", {imem_req, state_o}, {1'b1, 3'd0});

    // imem never ready: ERR after TIMEOUT wait cycles
    do_reset();
    iw_cfg = 1000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("timeout_wait", state_o, 3'd0);
    end
    step();
    chk("timeout_err", {err, busy, state_o}, {2'b10, 3'd6});
    chk("err_strobes", {imem_req, ir_we, pc_we, reg_we, dmem_req}, 5'b00000);

    // illegal opcode
    do_reset();
    iw_cfg = 0;
    cu_memtoreg = 1'b0; cu_memwrite = 1'b0; cu_regwrite = 1'b1;
    cu_alucontrol = ALU_NOP; cu_branch = 2'b00;
    step();
    step();
    step();
    chk("illegal_err", {err, busy, state_o}, {2'b10, 3'd6});
    for (int i = 0; i < 3; i++) step();
    chk("illegal_sticky", {err, state_o, imem_req, pc_we, reg_we}, {1'b1, 3'd6, 3'b000});
    do_reset();
    chk("illegal_cleared", {err, state_o}, {1'b0, 3'd0});

    // rst while in EXEC of a jump: no strobe in the reset cycle
    iw_cfg = 0;
    cu_regwrite = 1'b0; cu_alucontrol = ALU_NOP; cu_branch = 2'b10;
    step();
    step();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("midrst_no_strobe", {pc_we, reg_we, ir_we, dmem_req, state_o}, {4'b0000, 3'd2});
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("midrst_fetch", {imem_req, state_o, instret}, {1'b1, 3'd0, 4'd0});

    // counter wrap
    do_reset();
    for (int i = 0; i < 16; i++)
      run_instr(1'b0, 1'b0, 1'b1, 5'b00000, 2'b00, 0, 0, 1'b0);
    step();
    chk("instret_wrap", instret, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the MIPS-subset core. It sits between the combinational instruction decoder (op/func → MemtoReg, MemWrite, RegWrite, ALUControl, Branch) and the datapath.
- Converts the decoder's single-cycle control word into timed enables: PC, instruction register, data memory, register file.
- Performs ready/req handshakes with instruction and data memory.
- Counts retired instructions and traps illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 255, maximum wait cycles for imem_ready/dmem_ready before entering ERR (1..65535).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- halt  in  1  stop request, honoured only at instruction boundary
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- ir_we  out  1  load instruction register
- cu_memtoreg  in  1  decoder MemtoReg (load)
- cu_memwrite  in  1  decoder MemWrite (store)
- cu_regwrite  in  1  decoder RegWrite
- cu_alucontrol  in  5  decoder ALUControl; 5'b11111 = no ALU op
- cu_branch  in  2  decoder Branch: 00 seq, 01 taken branch (zero-gated), 10 j/jal, 11 jr
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write qualifier, valid with dmem_req
- dmem_ready  in  1  data access complete this cycle
- pc_we  out  1  PC update strobe
- pc_sel  out  2  next-PC select, encoding as cu_branch
- reg_we  out  1  register file write strobe
- busy  out  1  high in any state except HALT and ERR
- err  out  1  sticky error flag
- instret  out  CNT_W  retired instruction count
- state_o  out  3  current state, for debug

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst, which is a decided interface fact.
- Reset effect: state=FETCH, err=0, instret=0, timeout counter=0, latched control word=0. All strobes (imem_req excluded) are 0 during the reset cycle. In the first cycle after reset, imem_req=1.
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6. Outputs are Moore-decoded from state, plus the ready inputs where stated.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 for that cycle, go to DECODE.
  - Otherwise, hold and count wait cycles.
- DECODE:
  - The decoder settles on the new IR.
  - Latch cu_memtoreg, cu_memwrite, cu_regwrite.
  - Illegal instruction is cu_alucontrol==11111 && cu_branch==00 && !cu_memwrite. An illegal instruction goes to ERR; otherwise go to EXEC.
- EXEC: the ALU zero flag is valid here, so cu_branch is sampled live in this state.
  - If cu_branch!=00: pc_we=1, pc_sel=cu_branch, retire, go to FETCH.
  - Else if latched load or store: go to MEM.
  - Else: go to WB.
- MEM:
  - dmem_req=1 and dmem_we=latched store, held stable until dmem_ready.
  - On ready with a store: pc_we=1, pc_sel=00, retire, go to FETCH.
  - On ready with a load: go to WB.
- WB: reg_we=latched regwrite; pc_we=1, pc_sel=00; retire; go to FETCH.
- Retire: instret increments by 1 in the retiring cycle and wraps modulo 2^CNT_W.
- Halt: any transition into FETCH (but not from reset) goes to HALT instead if halt=1. HALT returns to FETCH in the first cycle halt=0. halt has no effect mid-instruction.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each non-ready wait cycle.
  - When it reaches TIMEOUT while ready is still low, go to ERR.
  - Ready arriving in the same cycle the count would hit TIMEOUT wins; it completes normally.
- ERR: err=1, all strobes 0, busy=0. Only rst exits ERR.
- Strobe mutual exclusion: pc_we, reg_we, ir_we and dmem_req are never asserted outside their stated states.
- rst mid-instruction: aborts with no strobe in the rst cycle; the latched word is cleared.
- Latency with zero-wait memory:
  - ALU op: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - j, jr, taken branch: 3 cycles
  - Not-taken branch: 4 cycles, via WB with reg_we=0

Decomposition:
- Shared package mc_pkg holds:
  - the state enum/localparams (FETCH..ERR);
  - Branch/pc_sel codes SEL_SEQ=00, SEL_BR=01, SEL_J=10, SEL_JR=11;
  - ALU_NOP=5'b11111.
- One sub-module, mc_wait_timer: loadable wait counter with clear, enable and expired output, sized by TIMEOUT. The FSM, latch and instret stay in mc_sequencer.

Test Plan:
- add, zero-wait memory: rst 1 cycle, imem_ready=1, cu_alucontrol=00000, cu_regwrite=1 → ir_we at cycle 1, reg_we and pc_we at cycle 4 with pc_sel=00, instret=1.
- lw with dmem_ready delayed 3 cycles: cu_memtoreg=1, cu_regwrite=1 → dmem_req high 4 cycles with dmem_we=0, then WB with reg_we=1; total 8 cycles, instret +1.
- beq taken / jr / j: cu_branch=01 / 11 / 10 in EXEC → pc_we=1 with matching pc_sel, no reg_we, 3 cycles each; not-taken beq (cu_alucontrol=01101, cu_branch=00) → 4 cycles, reg_we=0.
- Illegal: cu_alucontrol=11111, cu_branch=00, cu_memwrite=0 at DECODE → ERR next cycle, err=1, busy=0; held until rst, then state_o=0.
- Timeout with TIMEOUT=4: imem_ready held 0 → ERR after 4 wait cycles; repeat with ready in the 4th wait cycle → normal DECODE.
- Halt: assert halt during EXEC of an add → retires, enters HALT (state_o=5, imem_req=0); deassert → FETCH next cycle.
- Wrap: force CNT_W=4, retire 16 instructions → instret wraps to 0.
